// File: rtl/dwt_pkg.sv
// Shared definitions for the 5/3 lifting DWT blocks: default widths, FSM states
// and the output saturation helper.
package dwt_pkg;

    localparam int unsigned COEF_W_DEF = 8;
    localparam int unsigned SAMP_W_DEF = 8;
    // Headroom above COEF_W so lifting sums never wrap.
    localparam int unsigned GUARD_W    = 3;

    typedef enum logic [1:0] {
        S_FIRST,
        S_RUN,
        S_FLUSH
    } state_e;

    // Saturate a signed value to the unsigned range [0, 2^w-1].
    function automatic logic [31:0] clamp_u(input logic signed [31:0] v, input int unsigned w);
        logic signed [31:0] hi;
        hi = (32'sd1 <<< w) - 32'sd1;
        if (v < 0) begin
            return '0;
        end
        if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/idwt_out_buf.sv
// Two-entry even/odd output register: presents even then odd, and reports when it
// can take a new pair in the same cycle the odd sample leaves.
module idwt_out_buf #(
    parameter int unsigned SAMP_W = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              load_i,
    input  logic [SAMP_W-1:0] even_i,
    input  logic [SAMP_W-1:0] odd_i,
    input  logic              last_i,
    output logic              free_o,
    output logic [SAMP_W-1:0] data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              line_done_o
);

    logic [SAMP_W-1:0] even_q;
    logic [SAMP_W-1:0] odd_q;
    logic              full_q;
    logic              phase_q;
    logic              last_q;

    assign free_o      = !full_q || (phase_q && out_ready_i);
    assign data_o      = phase_q ? odd_q : even_q;
    assign out_valid_o = full_q;
    assign line_done_o = full_q && phase_q && out_ready_i && last_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            even_q  <= '0;
            odd_q   <= '0;
            full_q  <= 1'b0;
            phase_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            even_q  <= even_i;
            odd_q   <= odd_i;
            full_q  <= 1'b1;
            phase_q <= 1'b0;
            last_q  <= last_i;
        end else if (full_q && out_ready_i) begin
            if (!phase_q) begin
                phase_q <= 1'b1;
            end else begin
                full_q  <= 1'b0;
                phase_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/idwt_1d53_line.sv
// Inverse 1-D integer 5/3 lifting: consumes (low, high) pairs and streams the
// reconstructed interleaved line, one sample per handshake.
module idwt_1d53_line
    import dwt_pkg::*;
#(
    parameter int unsigned COEF_W     = COEF_W_DEF,
    parameter int unsigned SAMP_W     = SAMP_W_DEF,
    parameter int unsigned LINE_PAIRS = 16
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic signed [COEF_W-1:0] low_i,
    input  logic signed [COEF_W-1:0] high_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic        [SAMP_W-1:0] data_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     line_done_o
);

    localparam int unsigned IW = COEF_W + GUARD_W;
    localparam int unsigned KW = $clog2(LINE_PAIRS + 1);

    typedef logic signed [IW-1:0] wide_t;

    state_e          state_q, state_d;
    logic   [KW-1:0] k_q, k_d;
    wide_t           e_prev_q, e_prev_d;
    wide_t           h_prev_q, h_prev_d;

    wide_t l_cur, h_cur, h_left, e_cur, odd_prev, odd_last;

    logic              buf_load;
    logic              buf_last;
    logic              buf_free;
    logic [SAMP_W-1:0] buf_even;
    logic [SAMP_W-1:0] buf_odd;

    assign l_cur  = IW'(low_i);
    assign h_cur  = IW'(high_i);
    // First pair of a line mirrors H[0] into H[-1].
    assign h_left = (state_q == S_FIRST) ? h_cur : h_prev_q;

    assign e_cur    = l_cur - ((h_left + h_cur + wide_t'(2)) >>> 2);
    assign odd_prev = h_prev_q + ((e_prev_q + e_cur) >>> 1);
    assign odd_last = h_prev_q + e_prev_q;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        e_prev_d   = e_prev_q;
        h_prev_d   = h_prev_q;
        in_ready_o = 1'b0;
        buf_load   = 1'b0;
        buf_last   = 1'b0;
        buf_even   = SAMP_W'(clamp_u(32'(e_prev_q), SAMP_W));
        buf_odd    = SAMP_W'(clamp_u(32'(odd_prev), SAMP_W));

        unique case (state_q)
            S_FIRST: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    e_prev_d = e_cur;
                    h_prev_d = h_cur;
                    k_d      = KW'(1);
                    state_d  = (LINE_PAIRS == 1) ? S_FLUSH : S_RUN;
                end
            end
            S_RUN: begin
                in_ready_o = buf_free;
                if (in_valid_i && buf_free) begin
                    buf_load = 1'b1;
                    e_prev_d = e_cur;
                    h_prev_d = h_cur;
                    k_d      = k_q + KW'(1);
                    if (k_q == KW'(LINE_PAIRS - 1)) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // Last odd sample uses e[N] = e[N-1].
                if (buf_free) begin
                    buf_load = 1'b1;
                    buf_last = 1'b1;
                    buf_odd  = SAMP_W'(clamp_u(32'(odd_last), SAMP_W));
                    k_d      = '0;
                    state_d  = S_FIRST;
                end
            end
            default: begin
                state_d = S_FIRST;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= S_FIRST;
            k_q      <= '0;
            e_prev_q <= '0;
            h_prev_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            e_prev_q <= e_prev_d;
            h_prev_q <= h_prev_d;
        end
    end

    idwt_out_buf #(
        .SAMP_W(SAMP_W)
    ) u_out_buf (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .load_i     (buf_load),
        .even_i     (buf_even),
        .odd_i      (buf_odd),
        .last_i     (buf_last),
        .free_o     (buf_free),
        .data_o     (data_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .line_done_o(line_done_o)
    );

endmodule
